// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions: FSM encoding,
// keyboard command bytes and default line timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // 120 us inhibit and 20 ms ack timeout at 100 MHz
    localparam int DEF_INHIBIT_CYCLES = 12000;
    localparam int DEF_TIMEOUT_CYCLES = 2000000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines, with a falling-edge
// strobe on the clock line. Flops reset to the idle-high level.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic clk_fall_o,
    output logic data_sync_o
);

    logic c_meta_q, c_sync_q, c_prev_q;
    logic d_meta_q, d_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            c_prev_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2_clk_i;
            c_sync_q <= c_meta_q;
            c_prev_q <= c_sync_q;
            d_meta_q <= ps2_data_i;
            d_sync_q <= d_meta_q;
        end
    end

    assign clk_sync_o  = c_sync_q;
    assign clk_fall_o  = c_prev_q & ~c_sync_q;
    assign data_sync_o = d_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// clock out 8 data + odd parity + stop, then check the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ecnt_q, ecnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic clk_sync, clk_fall, data_sync;
    logic tmo;
    logic [8:0] frame;
    logic [3:0] bidx;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_data_i (ps2_data_in),
        .clk_sync_o (clk_sync),
        .clk_fall_o (clk_fall),
        .data_sync_o(data_sync)
    );

    assign tmo = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;
        data_d  = data_q;
        par_d   = par_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // a pulse still showing means this cycle is too early
                if (tx_start && !done_q && !err_q) begin
                    data_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    cnt_d   = '0;
                    ecnt_d  = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REQ, ST_SEND: begin
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (clk_fall) begin
                        ecnt_d  = ecnt_q + 4'd1;
                        state_d = (ecnt_q == 4'd9) ? ST_ACK : ST_SEND;
                    end
                end
            end
            ST_ACK: begin
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (clk_fall) begin
                        ecnt_d = ecnt_q + 4'd1;
                        if (data_sync) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (clk_sync && data_sync) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // edge k (1..9) presents frame bit k-1; stop is the released line
    assign frame = {par_q, data_q};
    assign bidx  = ecnt_q - 4'd1;

    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = (state_q == ST_INHIBIT);
    assign ps2_data_oe = (state_q == ST_REQ) ||
                         ((state_q == ST_SEND) && !frame[bidx]);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard line model plus a per-cycle
// behavioural model of the host's frame timing and pulses.
module tb_ps2_host_tx;

    localparam int INH = 60;
    localparam int TMO = 3000;
    localparam int M_DONE = 0;
    localparam int M_ERR  = 1;
    localparam int M_TMO  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;

    bit         mdl_active = 1'b0;
    int         mdl_t0 = 0;
    int         mdl_mode = M_DONE;
    logic [7:0] mdl_byte = 8'h00;

    assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // start bit excluded: {stop, odd parity, data}
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2 == 0);
        return {1'b1, p, b};
    endfunction

    // reference model: what the host must show on every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {tx_busy, tx_done, tx_err,
                             ps2_clk_oe, ps2_data_oe}, 0);
            mdl_active = 1'b0;
        end else if (!mdl_active) begin
            chk("idle_outs", {tx_busy, tx_done, tx_err,
                              ps2_clk_oe, ps2_data_oe}, 0);
            if (tx_start) begin
                mdl_active = 1'b1;
                mdl_t0     = cyc;
                mdl_byte   = tx_data;
            end
        end else if (tx_done || tx_err) begin
            chk("end_outs", {tx_busy, ps2_clk_oe, ps2_data_oe}, 0);
            chk("pulse_kind", {tx_done, tx_err},
                (mdl_mode == M_DONE) ? 2'b10 : 2'b01);
            if (mdl_mode == M_TMO)
                chk("tmo_cycle", cyc, mdl_t0 + INH + 1 + TMO);
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            mdl_active = 1'b0;
        end else begin
            chk("busy", tx_busy, 1);
            chk("clk_oe", ps2_clk_oe,
                (cyc >= mdl_t0 + 1) && (cyc <= mdl_t0 + INH));
            if (cyc <= mdl_t0 + INH)
                chk("inh_data_oe", ps2_data_oe, 0);
            if (cyc == mdl_t0 + INH + 1)
                chk("req_data_oe", ps2_data_oe, 1);
            if (cyc >= mdl_t0 + INH + 1 + TMO) begin
                chk("no_end_pulse", 0, 1);
                mdl_active = 1'b0;
            end
        end
    end

    // keyboard: mode 0 acks, 1 leaves data high, 2 resets at edge 5
    task automatic device_frame(input int half, input int mode,
                                output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2_clk_line && !ps2_data_line) && n < INH + 100) begin
            tick(1);
            n++;
        end
        chk("req_seen", n < INH + 100, 1);
        tick(10);
        chk("start_bit", ps2_data_line, 0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode == 0) begin
                dev_data_low = 1'b1;
                tick(5);
            end
            dev_clk_low = 1'b1;
            if (k == 5 && mode == 2) begin
                tick(4);
                #3 rst_n = 1'b0;
                #1;
                chk("abort_outs", {tx_busy, tx_done, tx_err,
                                   ps2_clk_oe, ps2_data_oe}, 0);
                dev_clk_low = 1'b0;
                tick(3);
                rst_n = 1'b1;
                return;
            end
            tick(half);
            dev_clk_low = 1'b0;
            tick(half / 2);
            if (k <= 10) bits[k-1] = ps2_data_line;
            if (k == 11) dev_data_low = 1'b0;
            tick(half - half / 2);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int mode,
                             input int half, input bit use_lit,
                             input logic [9:0] lit, input bit inject);
        logic [9:0] bits;
        int d0, e0, n;
        d0 = n_done;
        e0 = n_err;
        mdl_mode = (mode == 0) ? M_DONE : M_ERR;
        tx_data  = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        fork
            device_frame(half, mode, bits);
            if (inject) begin
                tick(INH + 100);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
            end
        join
        if (mode == 2) begin
            tick(50);
            chk("abort_pulses", (n_done - d0) + (n_err - e0), 0);
        end else begin
            chk("frame_bits", bits, use_lit ? lit : frame_of(mdl_byte));
            n = 0;
            while (mdl_active && n < 300) begin
                tick(1);
                n++;
            end
            chk("frame_end", mdl_active, 0);
            chk("n_done", n_done - d0, mode == 0);
            chk("n_err", n_err - e0, mode == 1);
        end
    endtask

    initial begin
        int n, d0, e0;
        tick(5);
        chk("reset_outs", {tx_busy, tx_done, tx_err,
                           ps2_clk_oe, ps2_data_oe}, 0);
        rst_n = 1'b1;
        tick(5);

        // 0xED with a mid-frame 0x55 request that must be ignored
        run_frame(8'hED, 0, 20, 1'b1, 10'h3ED, 1'b1);
        tick(7);
        // 0x01 without ack: parity bit 0, error pulse
        run_frame(8'h01, 1, 20, 1'b1, 10'h201, 1'b0);
        tick(7);

        // no device activity: timeout
        d0 = n_done;
        e0 = n_err;
        mdl_mode = M_TMO;
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        n = 0;
        while (mdl_active && n < INH + TMO + 50) begin
            tick(1);
            n++;
        end
        chk("tmo_end", mdl_active, 0);
        chk("tmo_err", n_err - e0, 1);
        chk("tmo_done", n_done - d0, 0);
        tick(5);

        // reset at SEND edge 5, then a clean 0xF4
        run_frame(8'hFF, 2, 20, 1'b0, 10'h000, 1'b0);
        tick(5);
        run_frame(8'hF4, 0, 20, 1'b1, 10'h2F4, 1'b0);

        for (int i = 0; i < 4; i++) begin
            tick($urandom_range(1, 20));
            run_frame(8'($urandom), int'($urandom_range(0, 1)),
                      int'($urandom_range(15, 30)), 1'b0, 10'h000, 1'b0);
        end

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
